result_wb_ctrl: RTL and testbench



---
 rtl/wb_pkg.sv | 32 +++
 rtl/res_buf2.sv | 55 +++++
 rtl/result_wb_ctrl.sv | 159 +++++++++++++++
 tb/tb_result_wb_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg
// Shared definitions for the result write-back controller: FSM state
// encoding, default width constants and the output saturation helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } wb_state_t;

  localparam int unsigned DEF_MAC_NUM  = 8;
  localparam int unsigned DEF_ELEMENTS = 32;
  localparam int unsigned DEF_ACC_W    = 20;
  localparam int unsigned DEF_OUT_W    = 8;
  localparam int unsigned DEF_SHIFT    = 0;

  // Clamp a sign-extended value into the signed range of an out_w-bit word.
  // The caller keeps the low out_w bits of the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned        out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/res_buf2.sv
// res_buf2
// Two-entry (ping/pong) buffer holding whole groups of lane accumulators.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push, wdata   : store one group (caller guarantees !full or pop)
//   pop           : release the oldest group (caller guarantees !empty)
//   rdata         : oldest group, valid while !empty
//   full, empty   : occupancy flags
// A push while full is legal only together with a pop; the freed slot is the
// one being written, since both pointers coincide when full.
module res_buf2 #(
  parameter int unsigned MAC_NUM = 8,
  parameter int unsigned ACC_W   = 20
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [MAC_NUM*ACC_W-1:0] wdata,
  output logic [MAC_NUM*ACC_W-1:0] rdata,
  output logic                     full,
  output logic                     empty
);

  logic [MAC_NUM*ACC_W-1:0] mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/result_wb_ctrl.sv
// result_wb_ctrl
// Write-back stage behind the PU/MAC array. On each pu_clear_i in RUN the
// MAC_NUM lane accumulators are captured into a ping/pong buffer, then
// shifted, saturated and written one word per cycle to the output RAM.
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   start_i                : begins a run when sampled in IDLE
//   pu_clear_i, pu_data_i  : group-complete strobe and lane accumulators
//   dout_addr/data/we_o    : output RAM write port
//   busy_o                 : RUN or DRAIN
//   overflow_o             : sticky, a group was dropped (buffer full)
//   done_o                 : one-cycle pulse after the last write
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting groups until ELEMENTS/MAC_NUM have been captured
// DRAIN | no more captures, writing out what is buffered
// DONE  | one-cycle completion pulse
module result_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned MAC_NUM  = DEF_MAC_NUM,
  parameter int unsigned ELEMENTS = DEF_ELEMENTS,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned SHIFT    = DEF_SHIFT
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic                        pu_clear_i,
  input  logic [MAC_NUM*ACC_W-1:0]    pu_data_i,
  output logic [$clog2(ELEMENTS)-1:0] dout_addr_o,
  output logic [OUT_W-1:0]            dout_data_o,
  output logic                        dout_we_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic                        done_o
);

  localparam int unsigned GROUPS = ELEMENTS / MAC_NUM;
  localparam int unsigned ADDR_W = $clog2(ELEMENTS);
  localparam int unsigned LANE_W = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;
  localparam int unsigned GRP_W  = $clog2(GROUPS + 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(MAC_NUM - 1);

  wb_state_t state;
  wb_state_t state_nxt;
  logic      run_start;

  logic [MAC_NUM*ACC_W-1:0] buf_rdata;
  logic                     buf_full;
  logic                     buf_empty;

  logic [LANE_W-1:0] lane_left;
  logic [LANE_W-1:0] lane_idx;
  logic [GRP_W-1:0]  grp_left;
  logic [ADDR_W-1:0] word_cnt;

  logic capture;
  logic accept;
  logic drop;
  logic pop;

  logic signed [ACC_W-1:0] lane_acc;
  logic signed [63:0]      acc_ext;
  logic [OUT_W-1:0]        conv;

  // The serializer runs whenever the buffer holds a group; the entry is
  // released on the edge that issues its final lane, which is what lets a
  // capture on that same edge succeed even with both slots occupied.
  assign pop     = !buf_empty && (lane_left == '0);
  assign capture = (state == ST_RUN) && pu_clear_i;
  assign accept  = capture && (!buf_full || pop);
  assign drop    = capture && !accept;

  res_buf2 #(
    .MAC_NUM (MAC_NUM),
    .ACC_W   (ACC_W)
  ) u_buf (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (accept),
    .pop    (pop),
    .wdata  (pu_data_i),
    .rdata  (buf_rdata),
    .full   (buf_full),
    .empty  (buf_empty)
  );

  assign lane_idx = LANE_LAST - lane_left;
  assign lane_acc = buf_rdata[lane_idx*ACC_W +: ACC_W];
  assign acc_ext  = 64'(lane_acc);
  assign conv     = OUT_W'(saturate(acc_ext >>> SHIFT, OUT_W));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_RUN;
          run_start = 1'b1;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (accept && (grp_left == GRP_W'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        // Empty here means the final lane was issued on the previous edge.
        if (buf_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grp_left    <= '0;
      lane_left   <= LANE_LAST;
      word_cnt    <= '0;
      overflow_o  <= 1'b0;
      dout_addr_o <= '0;
      dout_data_o <= '0;
      dout_we_o   <= 1'b0;
    end else begin
      if (run_start) begin
        grp_left   <= GRP_W'(GROUPS);
        word_cnt   <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (accept) grp_left   <= grp_left - GRP_W'(1);
        if (drop)   overflow_o <= 1'b1;
      end

      dout_we_o <= !buf_empty;
      if (!buf_empty) begin
        dout_addr_o <= word_cnt;
        dout_data_o <= conv;
        word_cnt    <= word_cnt + ADDR_W'(1);
        lane_left   <= (lane_left == '0) ? LANE_LAST : lane_left - LANE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_wb_ctrl.sv
module tb_result_wb_ctrl;

  localparam int M  = 8;
  localparam int E  = 32;
  localparam int G  = E / M;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          clr;
  logic [M*AW-1:0] pdata;

  logic [4:0] addr, addr4;
  logic [7:0] data, data4;
  logic       we, we4, busy, busy4, ovf, ovf4, done, done4;

  result_wb_ctrl #(.MAC_NUM(M), .ELEMENTS(E), .ACC_W(AW), .OUT_W(8), .SHIFT(0)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .pu_clear_i(clr), .pu_data_i(pdata),
    .dout_addr_o(addr), .dout_data_o(data), .dout_we_o(we),
    .busy_o(busy), .overflow_o(ovf), .done_o(done));

  result_wb_ctrl #(.MAC_NUM(M), .ELEMENTS(E), .ACC_W(AW), .OUT_W(8), .SHIFT(4)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .pu_clear_i(clr), .pu_data_i(pdata),
    .dout_addr_o(addr4), .dout_data_o(data4), .dout_we_o(we4),
    .busy_o(busy4), .overflow_o(ovf4), .done_o(done4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int wcyc;
    int waddr;
    int acc;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  run_active = 0;
  bit  ovf_exp = 0;
  int  grp_cnt = 0;
  int  last_sched = 0;
  int  done_exp = -10;
  int  lanes[M];

  // Reference conversion: arithmetic shift then clamp to signed 8 bits.
  function automatic logic [7:0] conv(input int acc, input int sh);
    int v;
    v = acc >>> sh;
    if (v > 127) return 8'd127;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  // Scoreboard: expected writes carry the cycle they must appear in.
  always @(negedge clk) begin
    bit  ew;
    wr_t e;
    if (rstn) begin
      ew = (exp_q.size() > 0) && (exp_q[0].wcyc == cyc);
      n_cmp++;
      if (we !== ew) begin
        n_fail++;
        $display("FAIL write_enable cyc=%0d: got %0b expected %0b", cyc, we, ew);
      end
      n_cmp++;
      if (we4 !== ew) begin
        n_fail++;
        $display("FAIL write_enable_shift4 cyc=%0d: got %0b expected %0b", cyc, we4, ew);
      end
      if (ew) begin
        e = exp_q.pop_front();
        if (we) begin
          n_cmp++;
          if (addr !== 5'(e.waddr)) begin
            n_fail++;
            $display("FAIL addr cyc=%0d: got %0d expected %0d", cyc, addr, e.waddr);
          end
          n_cmp++;
          if (addr4 !== 5'(e.waddr)) begin
            n_fail++;
            $display("FAIL addr_shift4 cyc=%0d: got %0d expected %0d", cyc, addr4, e.waddr);
          end
          n_cmp++;
          if (data !== conv(e.acc, 0)) begin
            n_fail++;
            $display("FAIL data cyc=%0d acc=%0d: got %0d expected %0d", cyc, e.acc,
                     $signed(data), $signed(conv(e.acc, 0)));
          end
          n_cmp++;
          if (data4 !== conv(e.acc, 4)) begin
            n_fail++;
            $display("FAIL data_shift4 cyc=%0d acc=%0d: got %0d expected %0d", cyc, e.acc,
                     $signed(data4), $signed(conv(e.acc, 4)));
          end
        end
      end
      n_cmp++;
      if (done !== (cyc == done_exp)) begin
        n_fail++;
        $display("FAIL done cyc=%0d: got %0b expected %0b", cyc, done, (cyc == done_exp));
      end
      n_cmp++;
      if (done4 !== (cyc == done_exp)) begin
        n_fail++;
        $display("FAIL done_shift4 cyc=%0d: got %0b expected %0b", cyc, done4, (cyc == done_exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < M; i++) lanes[i] = int'($urandom_range(0, 20'hFFFFF)) - 524288;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    run_active = 1;
    grp_cnt = 0;
    ovf_exp = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %0b expected 1", busy);
    end
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_after_start: got %0b expected 0", ovf);
    end
  endtask

  // Drives one clear pulse with the current lanes[] and updates the model.
  // A group is accepted when fewer than two groups still have words pending
  // after the capture edge.
  task automatic drive_clear();
    int c, pend, occ, base;
    for (int i = 0; i < M; i++) pdata[i*AW +: AW] = AW'(lanes[i]);
    clr = 1'b1;
    c = cyc + 1;
    if (run_active) begin
      pend = 0;
      foreach (exp_q[k]) if (exp_q[k].wcyc > c) pend++;
      occ = (pend + M - 1) / M;
      if (occ < 2) begin
        base = (last_sched + 1 > c + 1) ? last_sched + 1 : c + 1;
        for (int i = 0; i < M; i++) exp_q.push_back(wr_t'{base + i, grp_cnt * M + i, lanes[i]});
        last_sched = base + M - 1;
        grp_cnt++;
        if (grp_cnt == G) begin
          run_active = 0;
          done_exp = last_sched + 1;
        end
      end else begin
        ovf_exp = 1;
      end
    end
    tick(1);
    clr = 1'b0;
    n_cmp++;
    if (ovf !== ovf_exp) begin
      n_fail++;
      $display("FAIL overflow cyc=%0d: got %0b expected %0b", cyc, ovf, ovf_exp);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((run_active || exp_q.size() > 0 || cyc <= done_exp) && t < 400) begin
      tick(1);
      t++;
    end
    n_cmp++;
    if (t >= 400) begin
      n_fail++;
      $display("FAIL run_timeout: got pending=%0d expected 0", exp_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: got %0b expected 0", busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if (we !== 1'b0 || addr !== 5'd0 || data !== 8'd0) begin
      n_fail++;
      $display("FAIL %s_write_port: got we=%0b addr=%0d data=%0d expected 0/0/0", tag, we, addr, data);
    end
    n_cmp++;
    if (busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: got busy=%0b ovf=%0b done=%0b expected 0/0/0", tag, busy, ovf, done);
    end
    n_cmp++;
    if (we4 !== 1'b0 || ovf4 !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_shift4: got we=%0b ovf=%0b busy=%0b expected 0/0/0", tag, we4, ovf4, busy4);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; clr = 1'b0; pdata = '0;
    tick(3);
    check_idle_outputs("in_reset");
    rstn = 1'b1;
    tick(2);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_sequential();
    rand_lanes();
    drive_clear();            // ignored in IDLE
    tick(3);
    do_start();
    for (int g = 0; g < G; g++) begin
      for (int i = 0; i < M; i++) lanes[i] = 10 * g + i;
      drive_clear();
      if (g < G - 1) tick(9);
    end
    tick(3);
    rand_lanes();
    drive_clear();            // ignored in DRAIN
    wait_done();
  endtask

  task automatic test_saturation();
    int sat_l[M] = '{200, -300, 127, -128, 0, 1, -1, 524287};
    do_start();
    lanes = sat_l;
    drive_clear();
    tick(9);
    rand_lanes();
    lanes[0] = -17; lanes[1] = 255; lanes[2] = -524288; lanes[3] = 2047;
    drive_clear();
    tick(9);
    for (int g = 0; g < 2; g++) begin
      rand_lanes();
      drive_clear();
      tick(9);
    end
    wait_done();
  endtask

  task automatic test_overflow();
    do_start();
    for (int p = 0; p < 3; p++) begin
      rand_lanes();
      drive_clear();
      tick(1);
    end
    tick(10);
    for (int p = 0; p < 2; p++) begin
      rand_lanes();
      drive_clear();
      tick(9);
    end
    wait_done();
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %0b expected 1", ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    rand_lanes(); drive_clear(); tick(1);
    rand_lanes(); drive_clear(); tick(5);
    rand_lanes(); drive_clear(); tick(7);   // lands on the final-lane edge with both slots full
    rand_lanes(); drive_clear();
    wait_done();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 3; r++) begin
      do_start();
      n = 0;
      while (run_active && n < 40) begin
        rand_lanes();
        drive_clear();
        tick($urandom_range(0, 11));
        n++;
      end
      wait_done();
    end
  endtask

  task automatic test_reset_midrun();
    int t;
    do_start();
    rand_lanes(); drive_clear(); tick(1);
    rand_lanes(); drive_clear(); tick(1);
    rand_lanes(); drive_clear();
    t = 0;
    while (!(we === 1'b1 && addr === 5'd3) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL lane3_wait_timeout: got addr=%0d expected 3", addr);
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    run_active = 0;
    grp_cnt = 0;
    ovf_exp = 0;
    done_exp = -10;
    last_sched = 0;
    check_idle_outputs("async_reset");
    tick(2);
    rstn = 1'b1;
    tick(6);
    do_start();
    for (int g = 0; g < G; g++) begin
      rand_lanes();
      drive_clear();
      tick(7);
    end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
